// File: rtl/fir_out_monitor.sv
// -----------------------------------------------------------------------------
// fir_out_monitor
//
// Streaming sink for the FIR filter output stream on the sclk domain.
// Each wide filter result is rounded (round-half-up) and saturated to a short
// signed sample. The sample magnitude is integrated over fixed power-of-two
// windows. The window envelope drives a hysteresis state machine whose ON
// state lights sign_led, indicating tone presence in the filter passband.
//
// Pipeline (edges counted from the edge that samples din_valid):
//   +0 input register      +1 rounding, sync check   +2 saturation / dout
//   +3 window integration  +4 LED state machine
//
// Ports:
//   sclk          in   single clock
//   s_rst         in   asynchronous active-high reset
//   din_valid     in   FIR output valid
//   din_sync      in   FIR output sync; expected high with every valid
//   din_data      in   FIR output data, signed, DIN_W bits
//   dout_valid    out  scaled sample valid
//   dout_data     out  scaled, saturated sample, signed, DOUT_W bits
//   sat_flag      out  saturation occurred, qualified with dout_valid
//   env_valid     out  one-cycle pulse when a window completes
//   env_value     out  sum of |sample| over the last window, held
//   sync_err_cnt  out  saturating count of valid-without-sync samples
//   sign_led      out  tone-present indicator
// -----------------------------------------------------------------------------
module fir_out_monitor #(
    parameter int DIN_W    = 31,
    parameter int DOUT_W   = 16,
    parameter int SHIFT    = 12,
    parameter int WIN_LOG2 = 10,
    parameter logic [DOUT_W+WIN_LOG2-1:0] THR_HI = 24'd300000,
    parameter logic [DOUT_W+WIN_LOG2-1:0] THR_LO = 24'd200000
) (
    input  logic                       sclk,
    input  logic                       s_rst,
    input  logic                       din_valid,
    input  logic                       din_sync,
    input  logic [DIN_W-1:0]           din_data,
    output logic                       dout_valid,
    output logic [DOUT_W-1:0]          dout_data,
    output logic                       sat_flag,
    output logic                       env_valid,
    output logic [DOUT_W+WIN_LOG2-1:0] env_value,
    output logic [7:0]                 sync_err_cnt,
    output logic                       sign_led
);

    localparam int ACC_W = DOUT_W + WIN_LOG2;

    // Rounding constant 2^(SHIFT-1) at the widened (DIN_W+1) width.
    localparam logic signed [DIN_W:0] RND = {{DIN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    // Saturation limits of the output sample, sign-extended to DIN_W+1 bits.
    localparam logic signed [DIN_W:0] SAT_MAX = (DIN_W + 1)'((2 ** (DOUT_W - 1)) - 1);
    localparam logic signed [DIN_W:0] SAT_MIN = ~SAT_MAX;

    localparam logic [DOUT_W-1:0] OUT_MAX = {1'b0, {(DOUT_W - 1){1'b1}}};
    localparam logic [DOUT_W-1:0] OUT_MIN = {1'b1, {(DOUT_W - 1){1'b0}}};

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_ARM = 2'd1;
    localparam logic [1:0] ST_ON  = 2'd2;

    // ---------------------------------------------------------------- stage 0
    logic                    in_valid;
    logic                    in_sync;
    logic signed [DIN_W-1:0] in_data;

    // NOTE: every flop here is assigned with <= so all stages sample the
    // pre-edge values of their neighbours; blocking assignments would let a
    // sample race through several stages in one edge.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            in_valid <= 1'b0;
            in_sync  <= 1'b0;
            in_data  <= '0;
        end else begin
            in_valid <= din_valid;
            in_sync  <= din_sync;
            in_data  <= din_data;
        end
    end

    // ---------------------------------------------------------------- stage 1
    logic signed [DIN_W:0] rnd_sum;
    logic signed [DIN_W:0] r_q;
    logic                  r_valid;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign rnd_sum = $signed({in_data[DIN_W-1], in_data}) + RND;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_valid      <= 1'b0;
            r_q          <= '0;
            sync_err_cnt <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_q <= rnd_sum >>> SHIFT;
            end
            // The sample is still processed; only the counter notes the error.
            if (in_valid && !in_sync && sync_err_cnt != 8'hFF) begin
                sync_err_cnt <= sync_err_cnt + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            sat_flag   <= 1'b0;
        end else begin
            dout_valid <= r_valid;
            sat_flag   <= 1'b0;
            if (r_valid) begin
                if (r_q > SAT_MAX) begin
                    dout_data <= OUT_MAX;
                    sat_flag  <= 1'b1;
                end else if (r_q < SAT_MIN) begin
                    dout_data <= OUT_MIN;
                    sat_flag  <= 1'b1;
                end else begin
                    dout_data <= r_q[DOUT_W-1:0];
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic [DOUT_W-1:0]   mag;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIN_LOG2-1:0] wcnt;

    // Unsigned magnitude: the most negative sample maps to 2^(DOUT_W-1),
    // which is representable in DOUT_W unsigned bits.
    assign mag     = dout_data[DOUT_W-1] ? (~dout_data + DOUT_W'(1)) : dout_data;
    assign acc_sum = acc + ACC_W'(mag);

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            acc       <= '0;
            wcnt      <= '0;
            env_valid <= 1'b0;
            env_value <= '0;
        end else begin
            env_valid <= 1'b0;
            if (dout_valid) begin
                if (&wcnt) begin
                    // Last sample of the window: publish and restart with no
                    // dead cycle, so the next sample opens the new window.
                    env_value <= acc_sum;
                    env_valid <= 1'b1;
                    acc       <= '0;
                    wcnt      <= '0;
                end else begin
                    acc  <= acc_sum;
                    wcnt <= wcnt + WIN_LOG2'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage 4
    logic [1:0] state;
    logic [1:0] state_nxt;

    // NOTE: state_nxt gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (env_valid) begin
            case (state)
                ST_OFF:  state_nxt = (env_value >= THR_HI) ? ST_ARM : ST_OFF;
                ST_ARM:  state_nxt = (env_value >= THR_HI) ? ST_ON  : ST_OFF;
                ST_ON:   state_nxt = (env_value <  THR_LO) ? ST_OFF : ST_ON;
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // sign_led is registered from the next state so it moves on the same edge
    // as the state register.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state    <= ST_OFF;
            sign_led <= 1'b0;
        end else begin
            state    <= state_nxt;
            sign_led <= (state_nxt == ST_ON);
        end
    end

endmodule
